fb_scanout_reader: RTL and testbench

//  Read side of the graphics double buffer. Generates 640x480@60 VGA timing on the
//  VGA clock, fetches the 240x160 BGR555 frame from the double buffer's VGA port,
//  and shows it 2x-scaled (480x320) centred with black letterbox.

---
 rtl/fb_scanout_reader_if.sv | 48 ++++
 rtl/fb_scanout_reader.sv | 216 +++++++++++++++++++++
 tb/tb_fb_scanout_reader.sv | 397 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fb_scanout_reader_if.sv
// fb_scanout_reader_if
//   Groups the framebuffer read port and the VGA pin bundle of the scanout
//   reader into one interface.
//   Optional feature macro: SCANOUT_BORDER_EN (adds border_color).
//
//   Signals
//     addr         [16:0] framebuffer read address (row*FB_WIDTH + col)
//     data         [14:0] pixel for the address issued RD_LATENCY cycles earlier
//                         ([4:0] R, [9:5] G, [14:10] B)
//     VGA_R/G/B    [3:0]  colour pins
//     VGA_HS/VS           sync pins, active-low
//     frame_end           one-cycle pulse, whole image fetched
//     border_color [14:0] letterbox colour (SCANOUT_BORDER_EN only)
//
//   Modports
//     master : the scanout reader (drives addr and pins, reads data)
//     slave  : memory side / pin observer
interface fb_scanout_reader_if;
    logic [16:0] addr;
    logic [14:0] data;
    logic [3:0]  VGA_R;
    logic [3:0]  VGA_G;
    logic [3:0]  VGA_B;
    logic        VGA_HS;
    logic        VGA_VS;
    logic        frame_end;
`ifdef SCANOUT_BORDER_EN
    logic [14:0] border_color;

    modport master (
        output addr, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, frame_end,
        input  data, border_color
    );
    modport slave (
        input  addr, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, frame_end,
        output data, border_color
    );
`else
    modport master (
        output addr, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, frame_end,
        input  data
    );
    modport slave (
        input  addr, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, frame_end,
        output data
    );
`endif
endinterface

// File: rtl/fb_scanout_reader.sv
// fb_scanout_reader
//   Read side of the graphics double buffer. Generates 640x480@60 VGA timing,
//   fetches the FB_WIDTH x FB_HEIGHT BGR555 frame through a fixed-latency read
//   port and shows it 2x scaled, centred, with a letterbox around it.
//   frame_end pulses for one cycle when the counters reach (0, Y_OFFSET +
//   2*FB_HEIGHT), well after the last image pixel was fetched, so a buffer
//   swap at that point never tears.
//   Optional feature macro: SCANOUT_BORDER_EN (letterbox shows border_color
//   instead of black; blanking stays black).
//
//   Ports
//     clock  VGA pixel clock
//     reset  synchronous, active-high
//     bus    fb_scanout_reader_if.master (addr, data, VGA_*, frame_end,
//            border_color when enabled)
//
//   Read port: there is no valid/ready. An address is issued on every
//   in-image cycle and the data input is taken as the answer to the address
//   issued exactly RD_LATENCY cycles earlier; the memory must keep up every
//   cycle. Counter -> pin latency is RD_LATENCY+2 cycles, fixed.
//
//   The H_*/V_* parameters default to standard 640x480@60 timing.
module fb_scanout_reader #(
    parameter int RD_LATENCY = 2,
    parameter int FB_WIDTH   = 240,
    parameter int FB_HEIGHT  = 160,
    parameter int X_OFFSET   = 80,
    parameter int Y_OFFSET   = 80,
    parameter int H_VISIBLE  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_TOTAL    = 800,
    parameter int V_VISIBLE  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_TOTAL    = 525
) (
    input  logic                clock,
    input  logic                reset,
    fb_scanout_reader_if.master bus
);
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);
    localparam int CW = $clog2(FB_WIDTH + 1);
    localparam int PL = RD_LATENCY;  // index of the stage aligned with data

    // ---------------- timing counters ----------------
    logic [HW-1:0] r_hc;
    logic [VW-1:0] r_vc;
    logic [HW-1:0] w_hc_next;
    logic [VW-1:0] w_vc_next;
    logic          w_h_wrap;
    logic          w_v_wrap;

    assign w_h_wrap = (r_hc == HW'(H_TOTAL - 1));
    assign w_v_wrap = (r_vc == VW'(V_TOTAL - 1));

    always_comb begin
        w_hc_next = w_h_wrap ? '0 : r_hc + HW'(1);
        w_vc_next = r_vc;
        if (w_h_wrap) begin
            w_vc_next = w_v_wrap ? '0 : r_vc + VW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_hc <= '0;
            r_vc <= '0;
        end else begin
            r_hc <= w_hc_next;
            r_vc <= w_vc_next;
        end
    end

    // ---------------- decode of the current counter ----------------
    logic w_vis;
    logic w_hs_n;
    logic w_vs_n;
    logic w_in_img;
    logic w_line_end;
    logic w_frame_end_next;

    assign w_vis  = (r_hc < HW'(H_VISIBLE)) && (r_vc < VW'(V_VISIBLE));
    assign w_hs_n = !((r_hc >= HW'(H_VISIBLE + H_FRONT)) &&
                      (r_hc <  HW'(H_VISIBLE + H_FRONT + H_SYNC)));
    assign w_vs_n = !((r_vc >= VW'(V_VISIBLE + V_FRONT)) &&
                      (r_vc <  VW'(V_VISIBLE + V_FRONT + V_SYNC)));
    assign w_in_img = (r_hc >= HW'(X_OFFSET)) &&
                      (r_hc <  HW'(X_OFFSET + 2 * FB_WIDTH)) &&
                      (r_vc >= VW'(Y_OFFSET)) &&
                      (r_vc <  VW'(Y_OFFSET + 2 * FB_HEIGHT));
    assign w_line_end = w_in_img && (r_hc == HW'(X_OFFSET + 2 * FB_WIDTH - 1));

    // frame_end is registered from the next counter value so the pulse
    // coincides with the counter sitting at (0, Y_OFFSET+2*FB_HEIGHT).
    assign w_frame_end_next = (w_hc_next == '0) &&
                              (w_vc_next == VW'(Y_OFFSET + 2 * FB_HEIGHT));

    // ---------------- incremental address generation ----------------
    // r_xphase: second copy of the current column (2x horizontal scale).
    // r_yphase: second copy of the current fb row (2x vertical scale);
    // row_base only advances after the odd image line.
    logic [16:0]   r_addr;
    logic [16:0]   r_row_base;
    logic [CW-1:0] r_col;
    logic          r_xphase;
    logic          r_yphase;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_addr     <= '0;
            r_row_base <= '0;
            r_col      <= '0;
            r_xphase   <= 1'b0;
            r_yphase   <= 1'b0;
        end else if (w_h_wrap && w_v_wrap) begin
            r_row_base <= '0;
            r_col      <= '0;
            r_xphase   <= 1'b0;
            r_yphase   <= 1'b0;
        end else if (w_in_img) begin
            r_addr <= r_row_base + 17'(r_col);
            if (w_line_end) begin
                r_col    <= '0;
                r_xphase <= 1'b0;
                r_yphase <= ~r_yphase;
                if (r_yphase) begin
                    r_row_base <= r_row_base + 17'(FB_WIDTH);
                end
            end else begin
                r_xphase <= ~r_xphase;
                if (r_xphase) begin
                    r_col <= r_col + CW'(1);
                end
            end
        end
    end

    assign bus.addr = r_addr;

    // ---------------- control pipeline, aligned with data ----------------
    // Stage 0 holds the control for the address register, stage PL lines up
    // with the data returning for that address.
    logic [PL:0] r_vis_p;
    logic [PL:0] r_img_p;
    logic [PL:0] r_hs_p;
    logic [PL:0] r_vs_p;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_vis_p <= '0;
            r_img_p <= '0;
            r_hs_p  <= '1;
            r_vs_p  <= '1;
        end else begin
            r_vis_p <= {r_vis_p[PL-1:0], w_vis};
            r_img_p <= {r_img_p[PL-1:0], w_in_img};
            r_hs_p  <= {r_hs_p[PL-1:0],  w_hs_n};
            r_vs_p  <= {r_vs_p[PL-1:0],  w_vs_n};
        end
    end

    // ---------------- registered outputs ----------------
    logic [3:0] r_vga_r;
    logic [3:0] r_vga_g;
    logic [3:0] r_vga_b;
    logic       r_vga_hs;
    logic       r_vga_vs;
    logic       r_frame_end;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_vga_r     <= 4'h0;
            r_vga_g     <= 4'h0;
            r_vga_b     <= 4'h0;
            r_vga_hs    <= 1'b1;
            r_vga_vs    <= 1'b1;
            r_frame_end <= 1'b0;
        end else begin
            r_vga_hs    <= r_hs_p[PL];
            r_vga_vs    <= r_vs_p[PL];
            r_frame_end <= w_frame_end_next;
            if (r_img_p[PL]) begin
                r_vga_r <= bus.data[4:1];
                r_vga_g <= bus.data[9:6];
                r_vga_b <= bus.data[14:11];
`ifdef SCANOUT_BORDER_EN
            end else if (r_vis_p[PL]) begin
                r_vga_r <= bus.border_color[4:1];
                r_vga_g <= bus.border_color[9:6];
                r_vga_b <= bus.border_color[14:11];
`endif
            end else begin
                r_vga_r <= 4'h0;
                r_vga_g <= 4'h0;
                r_vga_b <= 4'h0;
            end
        end
    end

`ifndef SCANOUT_BORDER_EN
    // Visibility only matters for the border colour; without it the
    // letterbox and blanking are both black.
    logic w_vis_unused;
    assign w_vis_unused = ^r_vis_p;
`endif

    assign bus.VGA_R     = r_vga_r;
    assign bus.VGA_G     = r_vga_g;
    assign bus.VGA_B     = r_vga_b;
    assign bus.VGA_HS    = r_vga_hs;
    assign bus.VGA_VS    = r_vga_vs;
    assign bus.frame_end = r_frame_end;

endmodule

// File: tb/tb_fb_scanout_reader.sv
// tb_fb_scanout_reader
//   Directed bench for fb_scanout_reader. The DUT runs with a shrunk video
//   geometry so that several whole frames fit in a short run:
//     line  56 clocks: visible 0..39, hsync 44..49
//     frame 28 lines : visible 0..19, vsync 22..23   -> 1568 clocks/frame
//     fb 8x6, image at hc 12..27, vc 4..15, frame_end at (0,16)
//   Counter -> pin latency is RD_LATENCY+2 = 4 clocks.
//   n = clocks since reset release; counter state during clock n is
//   (n % 56, (n / 56) % 28); pins during clock n show counter n-4.
module tb_fb_scanout_reader;
    localparam int HT    = 56;
    localparam int VT    = 28;
    localparam int FRAME = HT * VT;   // 1568
    localparam int LAT   = 4;
`ifdef SCANOUT_BORDER_EN
    localparam bit BORDER_BUILD = 1'b1;
`else
    localparam bit BORDER_BUILD = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    fb_scanout_reader_if bus();

    fb_scanout_reader #(
        .RD_LATENCY(2),
        .FB_WIDTH(8),
        .FB_HEIGHT(6),
        .X_OFFSET(12),
        .Y_OFFSET(4),
        .H_VISIBLE(40),
        .H_FRONT(4),
        .H_SYNC(6),
        .H_TOTAL(56),
        .V_VISIBLE(20),
        .V_FRONT(2),
        .V_SYNC(2),
        .V_TOTAL(28)
    ) dut (
        .clock(clk),
        .reset(reset),
        .bus(bus)
    );

    // ---------------- memory model: data = addr[14:0], 2-cycle latency ----
    logic [16:0] d1;
    logic [16:0] d2;
    logic        data_mode;     // 0: data = addr, 1: constant 15'h7FFF
    logic [14:0] border_val;
    always @(posedge clk) begin
        d1 <= bus.addr;
        d2 <= d1;
    end
    assign bus.data = data_mode ? 15'h7FFF : d2[14:0];
`ifdef SCANOUT_BORDER_EN
    assign bus.border_color = border_val;
`endif

    int n;
    always @(posedge clk) begin
        if (reset) n <= 0;
        else       n <= n + 1;
    end

    // ---------------- pin model ----------------
    function automatic logic [13:0] exp_pins(int k);
        int c, h, v, idx;
        logic [14:0] d;
        logic [3:0] r, g, b;
        logic hs, vs;
        if (k < LAT) return {1'b1, 1'b1, 12'h000};
        c  = k - LAT;
        h  = c % HT;
        v  = (c / HT) % VT;
        hs = !(h >= 44 && h < 50);
        vs = !(v >= 22 && v < 24);
        r = 4'h0; g = 4'h0; b = 4'h0;
        if (h >= 12 && h < 28 && v >= 4 && v < 16) begin
            if (data_mode) d = 15'h7FFF;
            else begin
                idx = ((v - 4) / 2) * 8 + (h - 12) / 2;
                d   = idx[14:0];
            end
            r = d[4:1]; g = d[9:6]; b = d[14:11];
        end else if (BORDER_BUILD && h < 40 && v < 20) begin
            r = border_val[4:1]; g = border_val[9:6]; b = border_val[14:11];
        end
        return {hs, vs, r, g, b};
    endfunction

    // ---------------- scoreboard / monitor ----------------
    logic [13:0] exp_q[$];
    logic        mon_en;
    int pix_bad, fe_bad, fe_cnt, max_addr, vs_falls, first_fall, last_fall, vs_period;
    int hs_low, vs_low, white_cnt, first_n;
    logic [13:0] first_got, first_exp;
    logic prev_vs;

    task automatic clear_stats();
        exp_q.delete();
        pix_bad = 0; fe_bad = 0; fe_cnt = 0; max_addr = 0;
        vs_falls = 0; first_fall = -1; last_fall = -1; vs_period = -1;
        hs_low = 0; vs_low = 0; white_cnt = 0; first_n = -1;
        first_got = '0; first_exp = '0; prev_vs = 1'b1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            logic [13:0] got, e;
            logic exp_fe;
            exp_q.push_back(exp_pins(n));
            e   = exp_q.pop_front();
            got = {bus.VGA_HS, bus.VGA_VS, bus.VGA_R, bus.VGA_G, bus.VGA_B};
            if (got !== e) begin
                if (pix_bad == 0) begin
                    first_n = n; first_got = got; first_exp = e;
                end
                pix_bad++;
            end
            exp_fe = ((n % HT) == 0) && (((n / HT) % VT) == 16);
            if (bus.frame_end !== exp_fe) fe_bad++;
            if (bus.frame_end === 1'b1) fe_cnt++;
            if (int'(bus.addr) > max_addr) max_addr = int'(bus.addr);
            if (prev_vs === 1'b1 && bus.VGA_VS === 1'b0) begin
                if (vs_falls == 0) first_fall = n;
                else vs_period = n - last_fall;
                last_fall = n;
                vs_falls++;
            end
            prev_vs = bus.VGA_VS;
            if (n >= LAT && n < LAT + HT && bus.VGA_HS === 1'b0) hs_low++;
            if (n >= LAT && n < LAT + FRAME) begin
                if (bus.VGA_VS === 1'b0) vs_low++;
                if ({bus.VGA_R, bus.VGA_G, bus.VGA_B} === 12'hFFF) white_cnt++;
            end
        end
    end

    int n_checks;
    int n_fail;

    // ---------------- driver tasks ----------------
    task automatic apply_reset(int cyc);
        mon_en = 1'b0;
        reset  = 1'b1;
        repeat (cyc) @(posedge clk);
        #2;
        reset = 1'b0;
        clear_stats();
        mon_en = 1'b1;
    endtask

    task automatic goto_cycle(int target);
        if (target > n) repeat (target - n) @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        apply_reset(3);
        n_checks++;
        if (bus.VGA_HS !== 1'b1) begin
            n_fail++; $display("FAIL reset_hs got %b exp 1", bus.VGA_HS);
        end
        n_checks++;
        if (bus.VGA_VS !== 1'b1) begin
            n_fail++; $display("FAIL reset_vs got %b exp 1", bus.VGA_VS);
        end
        n_checks++;
        if ({bus.VGA_R, bus.VGA_G, bus.VGA_B} !== 12'h000) begin
            n_fail++; $display("FAIL reset_rgb got %h exp 000", {bus.VGA_R, bus.VGA_G, bus.VGA_B});
        end
        n_checks++;
        if (bus.frame_end !== 1'b0) begin
            n_fail++; $display("FAIL reset_frame_end got %b exp 0", bus.frame_end);
        end
        n_checks++;
        if (bus.addr !== 17'd0) begin
            n_fail++; $display("FAIL reset_addr got %0d exp 0", bus.addr);
        end
    endtask

    task automatic test_timing();
        goto_cycle(2 * FRAME + 10);
        n_checks++;
        if (hs_low !== 6) begin
            n_fail++; $display("FAIL hs_low_per_line got %0d exp 6", hs_low);
        end
        n_checks++;
        if (vs_low !== 2 * HT) begin
            n_fail++; $display("FAIL vs_low_per_frame got %0d exp %0d", vs_low, 2 * HT);
        end
        n_checks++;
        if (first_fall !== 1236) begin
            n_fail++; $display("FAIL vs_first_fall got %0d exp 1236", first_fall);
        end
        n_checks++;
        if (vs_period !== FRAME) begin
            n_fail++; $display("FAIL vs_period got %0d exp %0d", vs_period, FRAME);
        end
        n_checks++;
        if (pix_bad !== 0) begin
            n_fail++;
            $display("FAIL timing_pixels got %0d bad (first n=%0d got %h exp %h) exp 0",
                     pix_bad, first_n, first_got, first_exp);
        end
        n_checks++;
        if (fe_bad !== 0) begin
            n_fail++; $display("FAIL timing_frame_end got %0d bad cycles exp 0", fe_bad);
        end
    endtask

    task automatic test_addr_gen();
        data_mode = 1'b0;
        apply_reset(2);
        goto_cycle(239);   // from counter (14,4): fb(0,1)
        n_checks++;
        if (bus.addr !== 17'd1) begin
            n_fail++; $display("FAIL addr_14_4 got %0d exp 1", bus.addr);
        end
        goto_cycle(252);   // from (27,4): fb(0,7)
        n_checks++;
        if (bus.addr !== 17'd7) begin
            n_fail++; $display("FAIL addr_27_4 got %0d exp 7", bus.addr);
        end
        goto_cycle(293);   // from (12,5): row 0 again
        n_checks++;
        if (bus.addr !== 17'd0) begin
            n_fail++; $display("FAIL addr_12_5 got %0d exp 0", bus.addr);
        end
        goto_cycle(351);   // from (14,6): fb(1,1)
        n_checks++;
        if (bus.addr !== 17'd9) begin
            n_fail++; $display("FAIL addr_14_6 got %0d exp 9", bus.addr);
        end
        goto_cycle(360);   // pin (20,6): fb 12 -> R = 12[4:1] = 6
        n_checks++;
        if ({bus.VGA_R, bus.VGA_G, bus.VGA_B} !== 12'h600) begin
            n_fail++; $display("FAIL pix_20_6 got %h exp 600", {bus.VGA_R, bus.VGA_G, bus.VGA_B});
        end
        goto_cycle(417);   // pin (21,7): same fb pixel, 2x scaled
        n_checks++;
        if ({bus.VGA_R, bus.VGA_G, bus.VGA_B} !== 12'h600) begin
            n_fail++; $display("FAIL pix_21_7 got %h exp 600", {bus.VGA_R, bus.VGA_G, bus.VGA_B});
        end
        goto_cycle(871);   // pin (27,15): fb 47 -> R = 7
        n_checks++;
        if ({bus.VGA_R, bus.VGA_G, bus.VGA_B} !== 12'h700) begin
            n_fail++; $display("FAIL pix_last got %h exp 700", {bus.VGA_R, bus.VGA_G, bus.VGA_B});
        end
        goto_cycle(FRAME + LAT);
        n_checks++;
        if (max_addr !== 47) begin
            n_fail++; $display("FAIL addr_max got %0d exp 47", max_addr);
        end
        n_checks++;
        if (pix_bad !== 0) begin
            n_fail++;
            $display("FAIL addr_pixels got %0d bad (first n=%0d got %h exp %h) exp 0",
                     pix_bad, first_n, first_got, first_exp);
        end
    endtask

    task automatic test_frame_end();
        apply_reset(2);
        goto_cycle(3 * FRAME);
        n_checks++;
        if (fe_cnt !== 3) begin
            n_fail++; $display("FAIL frame_end_count got %0d exp 3", fe_cnt);
        end
        n_checks++;
        if (fe_bad !== 0) begin
            n_fail++; $display("FAIL frame_end_position got %0d bad cycles exp 0", fe_bad);
        end
        n_checks++;
        if (max_addr > 47) begin
            n_fail++; $display("FAIL frame_end_addr_max got %0d exp <=47", max_addr);
        end
    endtask

    task automatic test_constant_white();
        data_mode  = 1'b1;
        border_val = 15'h0000;
        apply_reset(2);
        goto_cycle(240);   // pin (12,4): first image pixel
        n_checks++;
        if ({bus.VGA_R, bus.VGA_G, bus.VGA_B} !== 12'hFFF) begin
            n_fail++; $display("FAIL white_12_4 got %h exp fff", {bus.VGA_R, bus.VGA_G, bus.VGA_B});
        end
        goto_cycle(256);   // pin (28,4): just right of the image
        n_checks++;
        if ({bus.VGA_R, bus.VGA_G, bus.VGA_B} !== 12'h000) begin
            n_fail++; $display("FAIL white_28_4 got %h exp 000", {bus.VGA_R, bus.VGA_G, bus.VGA_B});
        end
        goto_cycle(FRAME + LAT);
        n_checks++;
        if (white_cnt !== 192) begin
            n_fail++; $display("FAIL white_count got %0d exp 192", white_cnt);
        end
        n_checks++;
        if (pix_bad !== 0) begin
            n_fail++;
            $display("FAIL white_pixels got %0d bad (first n=%0d got %h exp %h) exp 0",
                     pix_bad, first_n, first_got, first_exp);
        end
    endtask

    task automatic test_mid_reset();
        data_mode = 1'b1;
        apply_reset(2);
        goto_cycle(468);   // counter (20,8), inside the image
        mon_en = 1'b0;
        reset  = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        n_checks++;
        if ({bus.VGA_HS, bus.VGA_VS} !== 2'b11) begin
            n_fail++; $display("FAIL midreset_sync got %b exp 11", {bus.VGA_HS, bus.VGA_VS});
        end
        n_checks++;
        if ({bus.VGA_R, bus.VGA_G, bus.VGA_B} !== 12'h000) begin
            n_fail++; $display("FAIL midreset_rgb got %h exp 000", {bus.VGA_R, bus.VGA_G, bus.VGA_B});
        end
        n_checks++;
        if ({bus.addr, bus.frame_end} !== 18'd0) begin
            n_fail++; $display("FAIL midreset_addr_fe got %0d/%b exp 0/0", bus.addr, bus.frame_end);
        end
        reset = 1'b0;
        clear_stats();
        mon_en = 1'b1;
        goto_cycle(2 * FRAME);
        n_checks++;
        if (pix_bad !== 0) begin
            n_fail++;
            $display("FAIL midreset_pixels got %0d bad (first n=%0d got %h exp %h) exp 0",
                     pix_bad, first_n, first_got, first_exp);
        end
        n_checks++;
        if (first_fall !== 1236) begin
            n_fail++; $display("FAIL midreset_vs_fall got %0d exp 1236", first_fall);
        end
        n_checks++;
        if (vs_period !== FRAME) begin
            n_fail++; $display("FAIL midreset_vs_period got %0d exp %0d", vs_period, FRAME);
        end
    endtask

`ifdef SCANOUT_BORDER_EN
    task automatic test_border();
        data_mode  = 1'b0;
        border_val = 15'h001F;
        apply_reset(2);
        goto_cycle(121);   // pin (5,2): letterbox
        n_checks++;
        if ({bus.VGA_R, bus.VGA_G, bus.VGA_B} !== 12'hF00) begin
            n_fail++; $display("FAIL border_5_2 got %h exp f00", {bus.VGA_R, bus.VGA_G, bus.VGA_B});
        end
        goto_cycle(161);   // pin (45,2): blanking
        n_checks++;
        if ({bus.VGA_R, bus.VGA_G, bus.VGA_B} !== 12'h000) begin
            n_fail++; $display("FAIL border_blank got %h exp 000", {bus.VGA_R, bus.VGA_G, bus.VGA_B});
        end
        goto_cycle(FRAME + LAT);
        n_checks++;
        if (pix_bad !== 0) begin
            n_fail++;
            $display("FAIL border_pixels got %0d bad (first n=%0d got %h exp %h) exp 0",
                     pix_bad, first_n, first_got, first_exp);
        end
    endtask
`endif

    // ---------------- sequence + report ----------------
    initial begin
        n_checks   = 0;
        n_fail     = 0;
        reset      = 1'b1;
        mon_en     = 1'b0;
        data_mode  = 1'b0;
        border_val = 15'h0000;
        clear_stats();
        test_reset();
        test_timing();
        test_addr_gen();
        test_frame_end();
        test_constant_white();
        test_mid_reset();
`ifdef SCANOUT_BORDER_EN
        test_border();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
